// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM-stage load/store port: word array, fixed-latency
// read pipe and an in-order response FIFO throttled by an outstanding counter.
module data_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2,
  parameter int MAX_OUT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [31:0]               req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_write,
  output logic                      rsp_err,
  output logic [$clog2(MAX_OUT):0]  outstanding
);
  localparam int DATA_W    = 32;
  localparam int MEM_WORDS = 2 ** ADDR_W;
  localparam int AW        = $clog2(MAX_OUT);
  localparam int CNT_W     = AW + 1;

  logic [DATA_W-1:0]  r_mem      [MEM_WORDS];
  logic [LATENCY-1:0] r_vld_pipe;
  logic [LATENCY-1:0] r_wr_pipe;
  logic [LATENCY-1:0] r_err_pipe;
  logic [DATA_W-1:0]  r_dat_pipe [LATENCY];
  logic [DATA_W-1:0]  r_fifo_dat [MAX_OUT];
  logic [MAX_OUT-1:0] r_fifo_wr;
  logic [MAX_OUT-1:0] r_fifo_err;
  logic [CNT_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_out;

  logic          w_acc;
  logic          w_err;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [AW-1:0] w_head;

  // Always false while MEM_WORDS == 2**ADDR_W; kept for a smaller array.
  assign w_err     = {1'b0, req_addr} >= (ADDR_W + 1)'(MEM_WORDS);
  assign req_ready = (r_out < CNT_W'(MAX_OUT));
  assign w_acc     = req_valid & req_ready;
  assign w_push    = r_vld_pipe[LATENCY-1];
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_head    = r_rd_ptr[AW-1:0];
  assign w_pop     = rsp_valid & rsp_ready;

  assign rsp_valid   = !w_empty;
  assign rsp_rdata   = rsp_valid ? r_fifo_dat[w_head] : '0;
  assign rsp_write   = rsp_valid & r_fifo_wr[w_head];
  assign rsp_err     = rsp_valid & r_fifo_err[w_head];
  assign outstanding = r_out;

  // Stage p0: array access at accept edge, then shift toward the FIFO tail.
  always_ff @(posedge clk) begin
    if (w_acc && req_write && !w_err) begin
      r_mem[req_addr] <= req_wdata;
    end
    r_wr_pipe[0]  <= req_write;
    r_err_pipe[0] <= w_err;
    r_dat_pipe[0] <= (req_write || w_err) ? '0 : r_mem[req_addr];
    for (int i = 1; i < LATENCY; i++) begin
      r_wr_pipe[i]  <= r_wr_pipe[i-1];
      r_err_pipe[i] <= r_err_pipe[i-1];
      r_dat_pipe[i] <= r_dat_pipe[i-1];
    end
    if (w_push) begin
      r_fifo_dat[r_wr_ptr[AW-1:0]] <= r_dat_pipe[LATENCY-1];
      r_fifo_wr[r_wr_ptr[AW-1:0]]  <= r_wr_pipe[LATENCY-1];
      r_fifo_err[r_wr_ptr[AW-1:0]] <= r_err_pipe[LATENCY-1];
    end
  end

  // Control: pipe valids, FIFO pointers and the outstanding count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_out      <= '0;
    end else begin
      r_vld_pipe[0] <= w_acc;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_acc, w_pop})
        2'b10:   r_out <= r_out + 1'b1;
        2'b01:   r_out <= r_out - 1'b1;
        default: r_out <= r_out;
      endcase
    end
  end

  // The counter bounds pipe+FIFO occupancy, so a push never meets a full FIFO.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(w_push && w_full));
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: stimulus pushes expected responses,
// a negedge monitor pops and compares them and tracks the outstanding count.
module tb_data_mem_responder;
  localparam int ADDR_W  = 10;
  localparam int LATENCY = 2;
  localparam int MAX_OUT = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [31:0]       rsp_rdata;
  logic              rsp_write;
  logic              rsp_err;
  logic [2:0]        outstanding;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_write(rsp_write), .rsp_err(rsp_err), .outstanding(outstanding)
  );

  typedef struct packed {
    logic        w;
    logic [31:0] d;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [1024];
  int          checks = 0;
  int          failures = 0;
  int          n_pop = 0;
  int          exp_out = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // One clock of stimulus; entered and left at 1 time unit after a rising edge.
  task automatic cyc(input logic v, input logic w, input logic [ADDR_W-1:0] a,
                     input logic [31:0] d, input logic rr, output logic took);
    exp_t e;
    req_valid = v; req_write = w; req_addr = a; req_wdata = d; rsp_ready = rr;
    @(negedge clk);
    took = v && req_ready;
    if (took) begin
      e.w = w;
      if (w) begin
        e.d = 32'h0;
        model[a] = d;
      end else begin
        e.d = model[a];
      end
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input logic rr);
    logic t;
    repeat (n) cyc(1'b0, 1'b0, '0, '0, rr, t);
  endtask

  // Monitor: response compare, head stability under backpressure, counter model.
  initial begin
    exp_t        e;
    logic        hold_v;
    logic [32:0] hold;
    hold_v = 1'b0;
    hold = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_v  = 1'b0;
        exp_out = 0;
      end else begin
        checks++;
        assert (outstanding <= 3'(MAX_OUT)) else begin
          failures++;
          $display("FAIL out_bound: got %0d limit %0d", outstanding, MAX_OUT);
        end
        chk("out_count", 32'(outstanding), 32'(exp_out));
        if (hold_v && rsp_valid)
          chk("hold_stable", {31'h0, rsp_write} ^ rsp_rdata, {31'h0, hold[32]} ^ hold[31:0]);
        hold_v = rsp_valid && !rsp_ready;
        hold   = {rsp_write, rsp_rdata};
        if (rsp_valid && rsp_ready) begin
          n_pop++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp: got write=%0b rdata=0x%08h expected none",
                     rsp_write, rsp_rdata);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_write", {31'h0, rsp_write}, {31'h0, e.w});
            chk("rsp_rdata", rsp_rdata, e.d);
            chk("rsp_err", {31'h0, rsp_err}, 32'h0);
          end
        end
        exp_out = exp_out + int'(req_valid && req_ready) - int'(rsp_valid && rsp_ready);
      end
    end
  end

  initial begin
    logic t;
    int   acc;
    int   base;
    #1 rst_n = 1'b0;
    #20;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_write", {31'h0, rsp_write}, 32'h0);
    chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("rst_outstanding", 32'(outstanding), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Store then load address 5, checking load latency in isolation.
    cyc(1'b1, 1'b1, 10'd5, 32'hDEADBEEF, 1'b1, t);
    chk("st5_acc", {31'h0, t}, 32'h1);
    idle(4, 1'b1);
    cyc(1'b1, 1'b0, 10'd5, 32'h0, 1'b1, t);
    chk("ld5_acc", {31'h0, t}, 32'h1);
    req_valid = 1'b0;
    @(negedge clk); chk("lat_n1", {31'h0, rsp_valid}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk); chk("lat_n2", {31'h0, rsp_valid}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_valid", {31'h0, rsp_valid}, 32'h1);
    chk("lat_rdata", rsp_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;

    // Preload 16..23, then 8 back-to-back loads at full rate.
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 1'b1, 10'(16 + i), 32'hA5A5_0000 + 32'(i) * 32'h111, 1'b1, t);
    idle(4, 1'b1);
    base = n_pop;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 10'(16 + i), 32'h0, 1'b1, t);
      chk("b2b_ready", {31'h0, t}, 32'h1);
    end
    chk("b2b_pops_a", 32'(n_pop - base), 32'd5);
    idle(2, 1'b1);
    chk("b2b_pops_b", 32'(n_pop - base), 32'd7);
    idle(1, 1'b1);
    chk("b2b_pops_c", 32'(n_pop - base), 32'd8);

    // Backpressure: exactly MAX_OUT accepted, then release.
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 10'(16 + i), 32'h0, 1'b0, t);
      acc += int'(t);
    end
    chk("bp_accepted", 32'(acc), 32'd4);
    chk("bp_outstanding", 32'(outstanding), 32'd4);
    chk("bp_req_ready", {31'h0, req_ready}, 32'h0);
    chk("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    base = n_pop;
    idle(1, 1'b1);
    chk("rel_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rel_out_3", 32'(outstanding), 32'd3);
    chk("rel_pops_1", 32'(n_pop - base), 32'd1);
    idle(1, 1'b1);
    chk("rel_out_2", 32'(outstanding), 32'd2);
    chk("rel_pops_2", 32'(n_pop - base), 32'd2);

    // Refill to full, then pop and request together.
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 10'(18 + i), 32'h0, 1'b0, t);
      acc += int'(t);
    end
    chk("refill_acc", 32'(acc), 32'd2);
    chk("full_out", 32'(outstanding), 32'd4);
    cyc(1'b1, 1'b0, 10'd20, 32'h0, 1'b1, t);
    chk("full_no_acc", {31'h0, t}, 32'h0);
    chk("full_pop_out", 32'(outstanding), 32'd3);
    cyc(1'b1, 1'b0, 10'd21, 32'h0, 1'b1, t);
    chk("accpop_acc", {31'h0, t}, 32'h1);
    chk("accpop_out", 32'(outstanding), 32'd3);

    // Randomised traffic over the preloaded window.
    for (int i = 0; i < 100; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
          10'(16 + $urandom_range(0, 7)), $urandom, $urandom_range(0, 3) != 0, t);
    idle(10, 1'b1);
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    chk("rand_out_zero", 32'(outstanding), 32'd0);

    // Reset with three loads in flight; memory survives.
    cyc(1'b1, 1'b1, 10'd9, 32'h0000_0909, 1'b1, t);
    idle(4, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 10'd16, 32'h0, 1'b0, t);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'h0, rsp_valid}, 32'h0);
    chk("mid_rst_out", 32'(outstanding), 32'h0);
    chk("mid_rst_ready", {31'h0, req_ready}, 32'h1);
    chk("mid_rst_rdata", rsp_rdata, 32'h0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    base = n_pop;
    cyc(1'b1, 1'b0, 10'd9, 32'h0, 1'b1, t);
    chk("post_rst_acc", {31'h0, t}, 32'h1);
    idle(3, 1'b0);
    chk("post_rst_valid", {31'h0, rsp_valid}, 32'h1);
    chk("post_rst_rdata", rsp_rdata, 32'h0000_0909);
    idle(3, 1'b1);
    chk("post_rst_pops", 32'(n_pop - base), 32'd1);
    chk("post_rst_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
